// File: rtl/switch_press_emulator.sv
// ---------------------------------------------------------------------------
// switch_press_emulator
//
// Purpose:
//   Drives one active-low push-button line (oSw, 0 = pressed, 1 = released)
//   from single-cycle press / release / click requests. After every edge
//   the line is held stable for HOLD_CNT cycles so a downstream debouncer
//   sees each edge. Requests that arrive while a hold is running are
//   dropped, never queued.
//
// Optional feature (macro SWEMU_BOUNCE_EN):
//   When defined, each edge starts with BOUNCE_N glitch phases of
//   BOUNCE_CNT cycles each. The first phase is at the new level. After the
//   last phase the line settles and the full HOLD_CNT hold runs. Without
//   the macro the line makes clean single edges and no bounce logic exists.
//
// Ports:
//   iClk        in   system clock
//   iRst        in   synchronous reset, active-high
//   iPressReq   in   single-cycle request: drive the line low
//   iReleaseReq in   single-cycle request: drive the line high
//   iClickReq   in   single-cycle request: press, hold, release, hold
//   oSw         out  emulated switch line (registered, 1 = released)
//   oBusy       out  high while a hold (or bounce) phase is running
//   oDone       out  one-cycle pulse in the last cycle of a completed op
//   oReqDrop    out  one-cycle pulse, the cycle after a request is ignored
// ---------------------------------------------------------------------------
module switch_press_emulator #(
  parameter int unsigned HOLD_CNT   = 2_000_000,
  parameter int unsigned CNT_W      = 22,
  parameter int unsigned BOUNCE_N   = 4,
  parameter int unsigned BOUNCE_CNT = 50_000
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iPressReq,
  input  logic iReleaseReq,
  input  logic iClickReq,
  output logic oSw,
  output logic oBusy,
  output logic oDone,
  output logic oReqDrop
);

  typedef enum logic [1:0] {
    UP_IDLE = 2'd0,
    DN_HOLD = 2'd1,
    DN_IDLE = 2'd2,
    UP_HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);

  // Elaboration-time parameter sanity check.
  if ((HOLD_CNT < 1) || ((BOUNCE_N % 2) != 0) || (BOUNCE_CNT < 1) ||
      ((64'd1 << CNT_W) <= 64'(HOLD_CNT)) ||
      ((64'd1 << CNT_W) < 64'(BOUNCE_CNT))) begin : g_param_check
    $error("switch_press_emulator: illegal parameter combination");
  end

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             click_r, click_n;
  logic             any_req_s;
  logic             drop_n, sw_n, busy_n, done_n;
  logic             bnc_done_s;    // current cycle: glitch phases finished
  logic             bnc_done_n_s;  // next cycle: glitch phases finished
  logic             bnc_flip_s;    // next cycle: line inverted by a glitch

`ifdef SWEMU_BOUNCE_EN
  localparam int unsigned      PH_W     = $clog2(BOUNCE_N + 2);
  localparam logic [PH_W-1:0]  PH_END   = PH_W'(BOUNCE_N);
  localparam logic [CNT_W-1:0] BNC_LAST = CNT_W'(BOUNCE_CNT - 1);

  logic [PH_W-1:0]  ph_r, ph_n;
  logic [CNT_W-1:0] bcnt_r, bcnt_n;
  logic             enter_hold_s;

  // Bounce phase sequencer: restarts on every hold entry, then steps one
  // phase every BOUNCE_CNT cycles until BOUNCE_N phases have elapsed.
  always_comb begin
    ph_n         = ph_r;
    bcnt_n       = bcnt_r;
    enter_hold_s = ((state_n == DN_HOLD) || (state_n == UP_HOLD)) &&
                   (state_n != state_r);
    if (enter_hold_s) begin
      ph_n   = '0;
      bcnt_n = '0;
    end else if (((state_r == DN_HOLD) || (state_r == UP_HOLD)) &&
                 (ph_r != PH_END)) begin
      if (bcnt_r == BNC_LAST) begin
        bcnt_n = '0;
        ph_n   = ph_r + PH_W'(1);
      end else begin
        bcnt_n = bcnt_r + CNT_W'(1);
      end
    end else begin
      ph_n   = ph_r;
      bcnt_n = bcnt_r;
    end
  end

  assign bnc_done_s   = (ph_r == PH_END);
  assign bnc_done_n_s = (ph_n == PH_END);
  // Odd phases show the opposite of the target level.
  assign bnc_flip_s   = !bnc_done_n_s && ph_n[0];

  // Bounce sequencer registers; idle value is "all phases done".
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ph_r   <= PH_END;
      bcnt_r <= '0;
    end else begin
      ph_r   <= ph_n;
      bcnt_r <= bcnt_n;
    end
  end
`else
  assign bnc_done_s   = 1'b1;
  assign bnc_done_n_s = 1'b1;
  assign bnc_flip_s   = 1'b0;
`endif

  assign any_req_s = iPressReq | iReleaseReq | iClickReq;

  // Next-state, hold counter, click flag and request-drop decision.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    click_n = click_r;
    drop_n  = 1'b0;
    case (state_r)
      UP_IDLE: begin
        if (iClickReq || iPressReq) begin
          state_n = DN_HOLD;
          cnt_n   = '0;
          click_n = iClickReq;
          drop_n  = iReleaseReq;
        end else begin
          drop_n  = iReleaseReq;
        end
      end
      DN_HOLD: begin
        drop_n = any_req_s;
        if (!bnc_done_s) begin
          cnt_n = '0;
        end else if (cnt_r == HOLD_LAST) begin
          cnt_n = '0;
          if (click_r) begin
            state_n = UP_HOLD;
          end else begin
            state_n = DN_IDLE;
          end
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      DN_IDLE: begin
        drop_n = iPressReq | iClickReq;
        if (iReleaseReq) begin
          state_n = UP_HOLD;
          cnt_n   = '0;
        end else begin
          state_n = DN_IDLE;
        end
      end
      UP_HOLD: begin
        drop_n = any_req_s;
        if (!bnc_done_s) begin
          cnt_n = '0;
        end else if (cnt_r == HOLD_LAST) begin
          cnt_n   = '0;
          state_n = UP_IDLE;
          click_n = 1'b0;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_n = UP_IDLE;
        cnt_n   = '0;
        click_n = 1'b0;
        drop_n  = 1'b0;
      end
    endcase
  end

  // Output look-ahead: oDone must be visible during the final hold cycle,
  // so it is registered from the next-cycle state/counter values.
  always_comb begin
    sw_n   = ((state_n == UP_IDLE) || (state_n == UP_HOLD)) ^ bnc_flip_s;
    busy_n = (state_n == DN_HOLD) || (state_n == UP_HOLD);
    done_n = bnc_done_n_s && (cnt_n == HOLD_LAST) &&
             ((state_n == UP_HOLD) || ((state_n == DN_HOLD) && !click_n));
  end

  // State and registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_r  <= UP_IDLE;
      cnt_r    <= '0;
      click_r  <= 1'b0;
      oSw      <= 1'b1;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oReqDrop <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      click_r  <= click_n;
      oSw      <= sw_n;
      oBusy    <= busy_n;
      oDone    <= done_n;
      oReqDrop <= drop_n;
    end
  end

endmodule
